// File: rtl/iobus_pkg.sv
// ---------------------------------------------------------------------------
// iobus_pkg : OTTER IOBUS address map, UART TX state encoding, status layout
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package iobus_pkg;

    localparam logic [31:0] SWITCHES_AD  = 32'h1100_0000;
    localparam logic [31:0] LEDS_AD      = 32'h1108_0000;
    localparam logic [31:0] SSEG_AD      = 32'h110C_0000;
    localparam logic [31:0] UART_DATA_AD = 32'h1110_0000;
    localparam logic [31:0] UART_STAT_AD = 32'h1110_0004;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_BUSY_BIT  = 2;
    localparam int STAT_OVF_BIT   = 3;
    localparam int STAT_COUNT_LSB = 8;

    function automatic logic [31:0] pack_status(
        input logic       full,
        input logic       empty,
        input logic       busy,
        input logic       ovf,
        input logic [3:0] count
    );
        logic [31:0] w;
        w                                    = '0;
        w[STAT_FULL_BIT]                     = full;
        w[STAT_EMPTY_BIT]                    = empty;
        w[STAT_BUSY_BIT]                     = busy;
        w[STAT_OVF_BIT]                      = ovf;
        w[STAT_COUNT_LSB+3:STAT_COUNT_LSB]   = count;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/iobus_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo : first-word fall-through FIFO with occupancy counter
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is still accepted when a pop frees a slot
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/iobus_uart_tx.sv
// ---------------------------------------------------------------------------
// iobus_uart_tx : IOBUS-mapped 8N1 UART transmitter with FIFO and status word
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module iobus_uart_tx
    import iobus_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] DATA_AD      = UART_DATA_AD,
    parameter logic [31:0] STAT_AD      = UART_STAT_AD
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] RD_DATA,
    output logic        RD_HIT,
    output logic        TX,
    output logic        TX_DONE
);

    localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

    uart_tx_state_t state_q;
    logic [15:0]    baud_q;
    logic [2:0]     bit_cnt_q;
    logic [7:0]     shift_q;
    logic           tx_q;
    logic           done_q;
    logic           ovf_q;
    logic           ovf_d;

    logic           data_hit;
    logic           stat_hit;
    logic           push;
    logic           pop;
    logic           ovf_set;
    logic           ovf_clr;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic [7:0]     fifo_dout;
    logic           unused_bits;

    assign data_hit = (IOBUS_ADDR == DATA_AD);
    assign stat_hit = (IOBUS_ADDR == STAT_AD);
    assign push     = IOBUS_WR && data_hit;
    assign pop      = (state_q == IDLE) && !fifo_empty;
    assign ovf_set  = push && fifo_full && !pop;
    assign ovf_clr  = IOBUS_WR && stat_hit && IOBUS_OUT[STAT_OVF_BIT];
    // Set wins over clear so an overflow in the clearing cycle is not lost
    assign ovf_d    = ovf_set | (ovf_q & ~ovf_clr);
    assign unused_bits = ^IOBUS_OUT[31:8];

    assign RD_HIT  = data_hit || stat_hit;
    assign RD_DATA = stat_hit ? pack_status(fifo_full, fifo_empty, state_q != IDLE,
                                            ovf_q, 4'(fifo_count))
                              : 32'h0;
    assign TX      = tx_q;
    assign TX_DONE = done_q;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (push),
        .pop   (pop),
        .din   (IOBUS_OUT[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (!fifo_empty) begin
                        shift_q   <= fifo_dout;
                        bit_cnt_q <= '0;
                        baud_q    <= '0;
                        tx_q      <= 1'b0;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (baud_q == BAUD_MAX) begin
                        baud_q  <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_q == BAUD_MAX) begin
                        baud_q <= '0;
                        if (bit_cnt_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_q == BAUD_MAX) begin
                        baud_q  <= '0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
